// File: rtl/dll_lock_seq.sv
// dll_lock_seq: power-up / lock sequencer for the 32-phase DLL macro.
// Runs on the DLL reference clock. It walks the DLL through reset and bias
// settling, then waits for a qualified lock. It reports locked/fail status and
// can optionally retry the lock with successive charge-pump codes.
//
// Ports:
//   CKIN        in   reference clock, rising edge
//   RESETN      in   synchronous active-low reset
//   en          in   1 = run sequence, 0 = return to IDLE
//   ref_ok      in   reference clock present (already synchronized)
//   lock_det    in   phase-detector lock indication (already synchronized)
//   cp_init     in   [2:0] initial charge-pump code
//   dll_reset   out  DLL RESET, active high
//   r_cp        out  [2:0] DLL charge-pump code
//   r_ibias_cp  out  DLL charge-pump bias enable
//   dll_locked  out  DLL locked and qualified
//   dll_fail    out  lock attempt exhausted; sticky until en=0
//   state       out  [2:0] debug view of the FSM encoding
//
// Optional feature macro: DLL_LOCK_SEQ_RETRY_EN.
//   When it is defined, a lock timeout steps r_cp and retries, up to MAX_RETRY
//   times, before the sequencer declares a failure.
//   When it is undefined, any lock timeout goes straight to FAIL.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE 0 | DLL held in reset, bias off, waiting for en & ref_ok
// RST  1 | DLL reset held for T_RST cycles
// BIAS 2 | bias on, DLL still in reset, for T_BIAS cycles
// WAIT 3 | DLL released; qualifying lock_det against the T_LOCK timeout
// LOCK 4 | locked; watching for LOSS_CNT consecutive lock_det=0 cycles
// FAIL 5 | lock exhausted; DLL parked in reset until en drops
module dll_lock_seq #(
  parameter int T_RST     = 16,
  parameter int T_BIAS    = 32,
  parameter int T_LOCK    = 4096,
  parameter int LOCK_CNT  = 64,
  parameter int LOSS_CNT  = 4,
  parameter int MAX_RETRY = 7,
  parameter int CW        = 16
) (
  input  logic       CKIN,
  input  logic       RESETN,
  input  logic       en,
  input  logic       ref_ok,
  input  logic       lock_det,
  input  logic [2:0] cp_init,
  output logic       dll_reset,
  output logic [2:0] r_cp,
  output logic       r_ibias_cp,
  output logic       dll_locked,
  output logic       dll_fail,
  output logic [2:0] state
);

  if (T_RST < 1 || T_BIAS < 1 || T_LOCK < 1 || LOCK_CNT < 1 || LOSS_CNT < 1 ||
      MAX_RETRY < 0 || T_RST >= 2**CW || T_BIAS >= 2**CW || T_LOCK >= 2**CW ||
      LOCK_CNT >= 2**CW || LOSS_CNT >= 2**CW) begin : g_param_err
    $error("dll_lock_seq: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_BIAS   = 3'd2,
    S_WAIT   = 3'd3,
    S_LOCKED = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  // Terminal counts: a state is left on the edge where its counter would hit N.
  localparam logic [CW-1:0] RST_LAST  = CW'(T_RST - 1);
  localparam logic [CW-1:0] BIAS_LAST = CW'(T_BIAS - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(T_LOCK - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CNT - 1);
  localparam logic [CW-1:0] LOSS_LAST = CW'(LOSS_CNT - 1);

  state_t        cur, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] run_cnt, run_nxt;
  logic [CW-1:0] loss_cnt, loss_nxt;
  logic [2:0]    r_cp_nxt;

`ifdef DLL_LOCK_SEQ_RETRY_EN
  localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry_cnt, retry_nxt;
`endif

  always_comb begin
    nxt      = cur;
    cnt_nxt  = cnt;
    run_nxt  = run_cnt;
    loss_nxt = loss_cnt;
    r_cp_nxt = r_cp;
`ifdef DLL_LOCK_SEQ_RETRY_EN
    retry_nxt = retry_cnt;
`endif
    case (cur)
      S_IDLE: begin
        if (en && ref_ok) begin
          nxt      = S_RST;
          r_cp_nxt = cp_init;
`ifdef DLL_LOCK_SEQ_RETRY_EN
          retry_nxt = '0;
`endif
        end
      end
      S_RST: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == RST_LAST) nxt = S_BIAS;
      end
      S_BIAS: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == BIAS_LAST) nxt = S_WAIT;
      end
      S_WAIT: begin
        cnt_nxt = cnt + 1'b1;
        run_nxt = lock_det ? run_cnt + 1'b1 : '0;
        // Lock is checked first so it wins a same-cycle timeout.
        if (lock_det && run_cnt == LOCK_LAST) begin
          nxt = S_LOCKED;
        end else if (cnt == TMO_LAST) begin
`ifdef DLL_LOCK_SEQ_RETRY_EN
          if (retry_cnt < RW'(MAX_RETRY)) begin
            nxt       = S_RST;
            r_cp_nxt  = r_cp + 3'd1;
            retry_nxt = retry_cnt + 1'b1;
          end else begin
            nxt = S_FAIL;
          end
`else
          nxt = S_FAIL;
`endif
        end
      end
      S_LOCKED: begin
`ifdef DLL_LOCK_SEQ_RETRY_EN
        retry_nxt = '0;
`endif
        loss_nxt = lock_det ? '0 : loss_cnt + 1'b1;
        if (!lock_det && loss_cnt == LOSS_LAST) nxt = S_RST;
      end
      S_FAIL: nxt = S_FAIL;
      default: nxt = S_IDLE;
    endcase

    // Aborts override everything above.
    // A retry step started in the same cycle as an abort is dropped,
    // so r_cp only moves when a retry really happens.
    if (!en || (!ref_ok && (cur == S_RST || cur == S_BIAS ||
                            cur == S_WAIT || cur == S_LOCKED))) begin
      nxt      = S_IDLE;
      r_cp_nxt = r_cp;
`ifdef DLL_LOCK_SEQ_RETRY_EN
      retry_nxt = retry_cnt;
`endif
    end

    if (nxt != cur) begin
      cnt_nxt  = '0;
      run_nxt  = '0;
      loss_nxt = '0;
    end
  end

  always_ff @(posedge CKIN) begin
    if (!RESETN) begin
      cur        <= S_IDLE;
      cnt        <= '0;
      run_cnt    <= '0;
      loss_cnt   <= '0;
      r_cp       <= 3'd0;
      dll_reset  <= 1'b1;
      r_ibias_cp <= 1'b0;
      dll_locked <= 1'b0;
      dll_fail   <= 1'b0;
`ifdef DLL_LOCK_SEQ_RETRY_EN
      retry_cnt  <= '0;
`endif
    end else begin
      cur        <= nxt;
      cnt        <= cnt_nxt;
      run_cnt    <= run_nxt;
      loss_cnt   <= loss_nxt;
      r_cp       <= r_cp_nxt;
      // Outputs are decoded from the next state so they change on the entry edge.
      dll_reset  <= (nxt == S_IDLE) || (nxt == S_RST) || (nxt == S_BIAS) || (nxt == S_FAIL);
      r_ibias_cp <= (nxt == S_BIAS) || (nxt == S_WAIT) || (nxt == S_LOCKED);
      dll_locked <= (nxt == S_LOCKED);
      dll_fail   <= (nxt == S_FAIL);
`ifdef DLL_LOCK_SEQ_RETRY_EN
      retry_cnt  <= retry_nxt;
`endif
    end
  end

  assign state = cur;

endmodule
